// File: rtl/elevator_req_queue.sv
// +-------------------------------------------------------------------------+
// | Module  : elevator_req_queue                                            |
// | Brief   : Synchronizes and debounces six buttons, latches pending floor |
// |           requests and registers the next floor to service.            |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module elevator_req_queue #(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       FB1,
  input  logic       FB2,
  input  logic       FB3,
  input  logic       CALL1,
  input  logic       CALL2,
  input  logic       CALL3,
  input  logic [1:0] CUR_FLOOR,
  input  logic       UD,
  input  logic       SERVE_VLD,
  output logic [2:0] FB_PEND,
  output logic [2:0] CALL_PEND,
  output logic [1:0] TARGET,
  output logic       TGT_VLD
);

  localparam logic [3:0] c_cnt_last = 4'(DB_CYCLES - 1);

  // Bits [2:0] are in-car buttons, [5:3] hall calls; bit index = floor - 1.
  logic [5:0] w_btn;
  logic [5:0] sync1_q, sync2_q;
  logic [5:0] w_deb;
  logic [5:0] deb_prev_q;
  logic [5:0] pend_q, pend_d;
  logic [2:0] w_clr;
  logic [2:0] w_p;
  logic [1:0] w_up, w_dn, w_hi, w_lo;
  logic       w_here;
  logic [1:0] tgt_d, tgt_q;
  logic       vld_q;

  assign w_btn = {CALL3, CALL2, CALL1, FB3, FB2, FB1};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_prev_q <= '0;
    end else begin
      sync1_q    <= w_btn;
      sync2_q    <= sync1_q;
      deb_prev_q <= w_deb;
    end
  end

  generate
    for (genvar i = 0; i < 6; i++) begin : g_deb
      logic [3:0] cnt_q;
      logic       deb_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
          deb_q <= 1'b0;
        end else if (sync2_q[i] != deb_q) begin
          if (cnt_q == c_cnt_last) begin
            deb_q <= ~deb_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end else begin
          cnt_q <= '0;
        end
      end

      assign w_deb[i] = deb_q;
    end
  endgenerate

  always_comb begin
    w_clr = 3'b000;
    if (SERVE_VLD) begin
      case (CUR_FLOOR)
        2'd1:    w_clr = 3'b001;
        2'd2:    w_clr = 3'b010;
        2'd3:    w_clr = 3'b100;
        default: w_clr = 3'b000;
      endcase
    end
  end

  // A debounced rising edge on the same edge as a serve clear wins.
  assign pend_d = (pend_q & ~{w_clr, w_clr}) | (w_deb & ~deb_prev_q);

  assign w_p  = pend_q[2:0] | pend_q[5:3];
  assign w_hi = w_p[2] ? 2'd3 : (w_p[1] ? 2'd2 : (w_p[0] ? 2'd1 : 2'd0));
  assign w_lo = w_p[0] ? 2'd1 : (w_p[1] ? 2'd2 : (w_p[2] ? 2'd3 : 2'd0));

  always_comb begin
    w_up   = 2'd0;
    w_dn   = 2'd0;
    w_here = 1'b0;
    case (CUR_FLOOR)
      2'd1: begin
        w_here = w_p[0];
        w_up   = w_p[1] ? 2'd2 : (w_p[2] ? 2'd3 : 2'd0);
      end
      2'd2: begin
        w_here = w_p[1];
        w_up   = w_p[2] ? 2'd3 : 2'd0;
        w_dn   = w_p[0] ? 2'd1 : 2'd0;
      end
      2'd3: begin
        w_here = w_p[2];
        w_dn   = w_p[1] ? 2'd2 : (w_p[0] ? 2'd1 : 2'd0);
      end
      default: ;
    endcase

    tgt_d = 2'd0;
    if (CUR_FLOOR == 2'd0) begin
      tgt_d = UD ? w_hi : w_lo;
    end else if (w_here) begin
      tgt_d = CUR_FLOOR;
    end else if (UD) begin
      tgt_d = (w_up != 2'd0) ? w_up : w_dn;
    end else begin
      tgt_d = (w_dn != 2'd0) ? w_dn : w_up;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      tgt_q  <= 2'd0;
      vld_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
      vld_q  <= (tgt_d != 2'd0);
    end
  end

  assign FB_PEND   = pend_q[2:0];
  assign CALL_PEND = pend_q[5:3];
  assign TARGET    = tgt_q;
  assign TGT_VLD   = vld_q;

endmodule

`default_nettype wire

// File: doc/elevator_req_queue.md
ELEVATOR_REQ_QUEUE -- requirements
Module: elevator_req_queue

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, consecutive stable synchronized cycles needed to accept a button level change (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-004 SHALL have ports FB1, FB2, FB3  input  1 each  raw asynchronous in-car floor buttons.
REQ-005 SHALL have ports CALL1, CALL2, CALL3  input  1 each  raw asynchronous hall call buttons.
REQ-006 SHALL have port CUR_FLOOR  input  2  floor the car is at (1..3; 0 = between floors).
REQ-007 SHALL have port UD  input  1  current car direction (1 = up, 0 = down).
REQ-008 SHALL have port SERVE_VLD  input  1  one-cycle pulse: car stopped at CUR_FLOOR with door open.
REQ-009 SHALL have port FB_PEND  output  3  latched pending in-car requests, bit n = floor n.
REQ-010 SHALL have port CALL_PEND  output  3  latched pending hall requests, bit n = floor n.
REQ-011 SHALL have port TARGET  output  2  next floor to service (0 = none).
REQ-012 SHALL have port TGT_VLD  output  1  high when TARGET is nonzero.

Function
REQ-013 SHALL pass each of the six buttons through a two-flop synchronizer before any other use.
REQ-014 SHALL debounce each synchronized button independently: per-button counter increments while sync value differs from debounced value, clears when equal; debounced value toggles and counter clears on the edge the counter would reach DB_CYCLES.
REQ-015 SHALL ignore any synchronized pulse shorter than DB_CYCLES cycles (no pending change).
REQ-016 SHALL set the matching FB_PEND/CALL_PEND bit one cycle after a debounced rising edge; debounced falling edges have no effect.
REQ-017 SHALL, for a clean press, assert pending exactly DB_CYCLES+2 clk edges after the first edge sampling the button high (6 with default).
REQ-018 SHALL, on SERVE_VLD with CUR_FLOOR = n (1..3), clear FB_PEND[n] and CALL_PEND[n] on that edge; SERVE_VLD with CUR_FLOOR = 0 has no effect.
REQ-019 SHALL keep a bit set when its debounced rising edge coincides with a SERVE_VLD clear for that floor (set wins).
REQ-020 SHALL hold pending bits indefinitely until cleared by REQ-018 or reset; repeated presses of a pending floor have no extra effect.
REQ-021 SHALL register TARGET each cycle from the current pending vector P = FB_PEND | CALL_PEND (one-cycle latency from pending to TARGET).
REQ-022 SHALL select TARGET in priority: (a) CUR_FLOOR if nonzero and P[CUR_FLOOR] set; (b) nearest pending floor in UD direction; (c) nearest pending floor opposite UD; (d) 0 if P = 0.
REQ-023 SHALL, when CUR_FLOOR = 0, select the lowest pending floor if UD = 0 and the highest if UD = 1.
REQ-024 SHALL drive TGT_VLD registered, equal to (TARGET != 0) in the same cycle.

Reset
REQ-025 SHALL on reset clear synchronizers, debounced values, debounce counters, FB_PEND = 000, CALL_PEND = 000, TARGET = 0, TGT_VLD = 0.
REQ-026 SHALL give reset priority over every set, clear or selection event on the same edge, including mid-debounce and mid-press.
REQ-027 SHALL require a fresh debounced rising edge after reset; a button held through reset deassertion is latched only after DB_CYCLES+2 edges of observed high following reset release (debounced value starts at 0).

Verification
REQ-028 SHALL pass: FB2 held high from edge 0, DB_CYCLES = 4 -> FB_PEND = 010 after edge 6, TARGET = 2, TGT_VLD = 1 after edge 7.
REQ-029 SHALL pass: CALL3 high for 3 synchronized cycles then low -> CALL_PEND stays 000, TARGET stays 0.
REQ-030 SHALL pass: pending floors 1 and 3, CUR_FLOOR = 2, UD = 1 -> TARGET = 3; same with UD = 0 -> TARGET = 1.
REQ-031 SHALL pass: FB_PEND = 100, CALL_PEND = 100, SERVE_VLD pulse with CUR_FLOOR = 3 -> both 000 next cycle, TARGET = 0 one cycle later; a coincident debounced CALL3 edge leaves CALL_PEND = 100.
REQ-032 SHALL pass: reset asserted for one edge while FB_PEND = 011 and a FB3 debounce is at count 3 -> all outputs 0 after that edge; FB3 still held latches only DB_CYCLES+2 edges after release.
